// File: rtl/i8255_pkg.sv
// Shared types and constants for the i8255 host-bus front end.
package i8255_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    COMMIT,
    ERROR
  } bus_state_t;

  localparam logic [1:0] ADDR_PA = 2'b00;
  localparam logic [1:0] ADDR_PB = 2'b01;
  localparam logic [1:0] ADDR_PC = 2'b10;
  localparam logic [1:0] ADDR_CW = 2'b11;

  // Read and write strobes asserted together are an illegal host cycle.
  function automatic logic strobe_conflict(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/i8255_bus_if_if.sv
// Pin-level host bus of the i8255: active-low strobes, address and split data bus.
interface i8255_bus_if_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] a_pin;
  logic [7:0] d_pin_in;
  logic [7:0] d_pin_out;
  logic       d_pin_oe;

  modport master (
    output cs_n, rd_n, wr_n, a_pin, d_pin_in,
    input  d_pin_out, d_pin_oe
  );

  modport slave (
    input  cs_n, rd_n, wr_n, a_pin, d_pin_in,
    output d_pin_out, d_pin_oe
  );
endinterface

// File: rtl/i8255_sync.sv
// Multi-flop synchroniser with a selectable reset level for asynchronous host pins.
module i8255_sync #(
  parameter int   WIDTH     = 1,
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= {WIDTH{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/i8255_bus_if.sv
// Host-bus front end: synchronises CPU strobes and turns them into clean
// single-cycle core commands, and drives pin read data while a read is open.
module i8255_bus_if
  import i8255_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  i8255_bus_if_if.slave    bus,
  output logic             core_cs,
  output logic             core_rd,
  output logic             core_wr,
  output logic [1:0]       core_a,
  output logic [7:0]       core_din,
  input  logic [7:0]       core_dout,
  output logic             rd_strobe,
  output logic             bus_err
);

  logic [2:0] strb_q;
  logic [9:0] ad_q;
  logic       s_cs, s_rd, s_wr;
  logic [1:0] s_a;
  logic [7:0] s_d;

  // Strobes idle high through reset so no phantom cycle appears on release.
  i8255_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_strb (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({bus.cs_n, bus.rd_n, bus.wr_n}),
    .q       (strb_q)
  );

  i8255_sync #(.WIDTH(10), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ad (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({bus.a_pin, bus.d_pin_in}),
    .q       (ad_q)
  );

  assign s_cs = ~strb_q[2];
  assign s_rd = ~strb_q[1];
  assign s_wr = ~strb_q[0];
  assign s_a  = ad_q[9:8];
  assign s_d  = ad_q[7:0];

  bus_state_t state_q, state_d;
  logic [7:0] rdata;
  logic [1:0] wa;
  logic [7:0] wd;
  logic [7:0] d_out;
  logic       d_oe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdata   <= '0;
      wa      <= '0;
      wd      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == READ) rdata <= core_dout;
      // Keep resampling so the last value before the write strobe release wins.
      if (state_q == WRITE) begin
        wa <= s_a;
        wd <= s_d;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    core_cs   = 1'b0;
    core_rd   = 1'b0;
    core_wr   = 1'b0;
    core_a    = s_a;
    d_oe      = 1'b0;
    d_out     = '0;
    rd_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_cs) begin
          if (strobe_conflict(s_rd, s_wr)) state_d = ERROR;
          else if (s_rd)                   state_d = READ;
          else if (s_wr)                   state_d = WRITE;
        end
      end
      READ: begin
        core_cs = 1'b1;
        core_rd = 1'b1;
        d_oe    = 1'b1;
        d_out   = rdata;
        if (s_wr) begin
          state_d = ERROR;
        end else if (!s_rd || !s_cs) begin
          state_d   = IDLE;
          rd_strobe = 1'b1;
        end
      end
      WRITE: begin
        core_a = wa;
        if (s_rd)       state_d = ERROR;
        else if (!s_cs) state_d = IDLE;
        else if (!s_wr) state_d = COMMIT;
      end
      COMMIT: begin
        core_cs = 1'b1;
        core_wr = 1'b1;
        core_a  = wa;
        state_d = IDLE;
      end
      ERROR: begin
        if (!s_rd && !s_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_err       = (state_d == ERROR) && (state_q != ERROR);
  assign core_din      = wd;
  assign bus.d_pin_out = d_out;
  assign bus.d_pin_oe  = d_oe;

endmodule

// File: tb/tb_i8255_bus_if.sv
// Scoreboard bench for i8255_bus_if: host cycles queue expected core commands.
module tb_i8255_bus_if;
  import i8255_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       core_cs, core_rd, core_wr, rd_strobe, bus_err;
  logic [1:0] core_a;
  logic [7:0] core_din;
  logic [7:0] core_dout;

  i8255_bus_if_if bus ();

  i8255_bus_if #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .core_cs   (core_cs),
    .core_rd   (core_rd),
    .core_wr   (core_wr),
    .core_a    (core_a),
    .core_din  (core_din),
    .core_dout (core_dout),
    .rd_strobe (rd_strobe),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int err_seen = 0;
  logic [9:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [9:0] exp_w;
  logic [7:0] exp_r;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every core command is matched against the queued expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_wr) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          check_val("unexpected_wr", 32'd1, 32'd0);
        end else begin
          exp_w = wr_q.pop_front();
          check_val("wr_a", 32'(core_a), 32'(exp_w[9:8]));
          check_val("wr_din", 32'(core_din), 32'(exp_w[7:0]));
        end
      end
      if (rd_strobe) begin
        rd_seen++;
        if (rd_q.size() == 0) begin
          check_val("unexpected_rd", 32'd1, 32'd0);
        end else begin
          exp_r = rd_q.pop_front();
          check_val("rd_data", 32'(bus.d_pin_out), 32'(exp_r));
        end
      end
      if (bus_err) err_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel 0: core_wr high, 1: d_pin_oe high, 2: d_pin_oe low
  task automatic measure(input int sel, input int max, output int lat);
    lat = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat == 0) begin
        if ((sel == 0 && core_wr) || (sel == 1 && bus.d_pin_oe) || (sel == 2 && !bus.d_pin_oe))
          lat = i;
      end
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    bus.a_pin    = a;
    bus.d_pin_in = d;
    bus.cs_n     = 1'b0;
    bus.wr_n     = 1'b0;
    wr_q.push_back({a, d});
    tick(6);
    bus.wr_n = 1'b1;
    tick(1);
    bus.cs_n = 1'b1;
    tick(2);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({core_cs, core_rd, core_wr, core_a, core_din, bus.d_pin_oe,
                bus.d_pin_out, rd_strobe, bus_err});
  endfunction

  int lat;
  int base;

  initial begin
    bus.cs_n     = 1'b1;
    bus.rd_n     = 1'b1;
    bus.wr_n     = 1'b1;
    bus.a_pin    = 2'b00;
    bus.d_pin_in = 8'h00;
    core_dout    = 8'h00;

    #12;
    check_val("reset_outs", all_outs(), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check_val("idle_outs", all_outs(), 32'd0);

    // Single write with latency check
    bus.a_pin    = ADDR_PA;
    bus.d_pin_in = 8'h5A;
    bus.cs_n     = 1'b0;
    bus.wr_n     = 1'b0;
    wr_q.push_back({ADDR_PA, 8'h5A});
    tick(6);
    bus.wr_n = 1'b1;
    measure(0, 6, lat);
    check_val("wr_latency", 32'(lat), 32'(LAT));
    tick(1);
    bus.cs_n = 1'b1;
    tick(3);
    check_val("wr_count_1", 32'(wr_seen), 32'd1);

    // Read with core_dout changing mid-read
    core_dout = 8'hC3;
    bus.a_pin = ADDR_PB;
    bus.cs_n  = 1'b0;
    bus.rd_n  = 1'b0;
    rd_q.push_back(8'hC3);
    measure(1, 5, lat);
    check_val("oe_rise_latency", 32'(lat), 32'(LAT));
    check_val("rd_core_a", 32'(core_a), 32'(ADDR_PB));
    check_val("rd_core_cmd", 32'({core_cs, core_rd, core_wr}), 32'b110);
    tick(1);
    core_dout = 8'h00;
    tick(1);
    @(negedge clk);
    check_val("rd_hold_data", 32'(bus.d_pin_out), 32'hC3);
    check_val("rd_hold_oe", 32'(bus.d_pin_oe), 32'd1);
    tick(1);
    bus.rd_n = 1'b1;
    measure(2, 6, lat);
    check_val("oe_fall_latency", 32'(lat), 32'(LAT));
    tick(1);
    bus.cs_n = 1'b1;
    tick(3);
    check_val("rd_count", 32'(rd_seen), 32'd1);

    // Data changes while wr_n is low; last stable value must win
    bus.a_pin    = ADDR_PC;
    bus.d_pin_in = 8'h11;
    bus.cs_n     = 1'b0;
    bus.wr_n     = 1'b0;
    tick(2);
    bus.d_pin_in = 8'h22;
    tick(4);
    bus.wr_n = 1'b1;
    wr_q.push_back({ADDR_PC, 8'h22});
    tick(1);
    bus.cs_n = 1'b1;
    tick(4);
    check_val("wr_count_2", 32'(wr_seen), 32'd2);

    // Read/write conflict
    base = err_seen;
    bus.cs_n = 1'b0;
    bus.rd_n = 1'b0;
    bus.wr_n = 1'b0;
    tick(6);
    @(negedge clk);
    check_val("err_oe", 32'(bus.d_pin_oe), 32'd0);
    check_val("err_pulse", 32'(err_seen - base), 32'd1);
    tick(1);
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
    tick(4);
    check_val("err_single", 32'(err_seen - base), 32'd1);
    host_write(ADDR_PB, 8'hA7);
    tick(4);
    check_val("wr_after_err", 32'(wr_seen), 32'd3);

    // Abort by chip-select release
    base = wr_seen;
    bus.a_pin    = ADDR_CW;
    bus.d_pin_in = 8'hFF;
    bus.cs_n     = 1'b0;
    bus.wr_n     = 1'b0;
    tick(5);
    bus.cs_n = 1'b1;
    tick(1);
    bus.wr_n = 1'b1;
    tick(6);
    check_val("abort_cs", 32'(wr_seen), 32'(base));

    // Abort by reset mid-write
    bus.a_pin    = ADDR_PC;
    bus.d_pin_in = 8'h3C;
    bus.cs_n     = 1'b0;
    bus.wr_n     = 1'b0;
    tick(6);
    reset_n = 1'b0;
    #1;
    check_val("reset_mid_outs", all_outs(), 32'd0);
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(8);
    check_val("abort_reset", 32'(wr_seen), 32'(base));

    // Back-to-back writes to the control word
    base = wr_seen;
    host_write(ADDR_CW, 8'h80);
    host_write(ADDR_CW, 8'h0F);
    host_write(ADDR_CW, 8'h9B);
    tick(5);
    check_val("b2b_count", 32'(wr_seen - base), 32'd3);

    check_val("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check_val("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check_val("err_total", 32'(err_seen), 32'd1);
    check_val("rd_total", 32'(rd_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
